// File: rtl/uart_evt_pkg.sv
// Shared types and defaults for the UART event scheduler.
package uart_evt_pkg;

   typedef enum logic {
      EVT_IDLE    = 1'b0,
      EVT_PRESENT = 1'b1
   } evt_state_e;

   localparam int N_EVT_DEF = 4;
   localparam int CNT_W_DEF = 8;

   // Width of a source index; never below one bit.
   function automatic int evt_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_evt_rr_arb.sv
// Combinational round-robin picker: searches ptr+1 .. N_EVT-1, 0 .. ptr and
// returns the first requesting source as one-hot and as an index.
module uart_evt_rr_arb
   import uart_evt_pkg::*;
#(
   parameter int N_EVT = N_EVT_DEF,
   parameter int ID_W  = evt_id_w(N_EVT)
) (
   input  logic [N_EVT-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_EVT-1:0] gnt_o,
   output logic [ID_W-1:0]  gnt_id_o,
   output logic             any_o
);

   // Walk the sources in rotated order and keep the first hit.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      any_o    = 1'b0;
      for (int i = 1; i <= N_EVT; i++) begin
         if (!any_o && req_i[ID_W'((int'(ptr_i) + i) % N_EVT)]) begin
            any_o    = 1'b1;
            gnt_o[ID_W'((int'(ptr_i) + i) % N_EVT)] = 1'b1;
            gnt_id_o = ID_W'((int'(ptr_i) + i) % N_EVT);
         end
      end
   end

endmodule

// File: rtl/uart_evt_sched.sv
// Event scheduler for the AHB UART: edge-detects synchronised event levels,
// holds them as pending bits and serialises them round-robin onto a
// valid/ready stream of source IDs. Lost events raise sticky overflow flags.
// Optional macro UART_EVT_OVF_CNT_EN adds saturating per-source lost-event
// counters on ovf_cnt_o; without it ovf_cnt_o is tied to zero.
//
//   state       | meaning
//   EVT_IDLE    | nothing presented, evt_valid_o low
//   EVT_PRESENT | evt_id_o presented, waiting for evt_ready_i
module uart_evt_sched
   import uart_evt_pkg::*;
#(
   parameter int N_EVT = N_EVT_DEF,
   parameter int ID_W  = evt_id_w(N_EVT),
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_EVT-1:0]       evt_i,
   input  logic [N_EVT-1:0]       evt_mask_i,
   input  logic                   evt_ready_i,
   output logic                   evt_valid_o,
   output logic [ID_W-1:0]        evt_id_o,
   output logic [N_EVT-1:0]       pend_o,
   output logic [N_EVT-1:0]       ovf_o,
   input  logic [N_EVT-1:0]       ovf_clr_i,
   output logic [N_EVT*CNT_W-1:0] ovf_cnt_o
);

   evt_state_e       state_q, state_d;
   logic [N_EVT-1:0] evt_d_q, evt_d_d;
   logic [N_EVT-1:0] pend_q, pend_d;
   logic [N_EVT-1:0] ovf_q, ovf_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;

   logic [N_EVT-1:0] rise, cap, req, gnt, gnt_vec, ovf_set;
   logic [ID_W-1:0]  gnt_id;
   logic             any, do_gnt;

   assign rise = evt_i & ~evt_d_q;
   assign cap  = rise & evt_mask_i;
   assign req  = pend_q & evt_mask_i;

   uart_evt_rr_arb #(
      .N_EVT (N_EVT),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .any_o    (any)
   );

   // Presentation FSM: grant when idle, or re-grant in the accept cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      do_gnt  = 1'b0;
      case (state_q)
         EVT_IDLE: begin
            if (any) begin
               do_gnt  = 1'b1;
               state_d = EVT_PRESENT;
            end
         end
         EVT_PRESENT: begin
            if (evt_ready_i) begin
               if (any) begin
                  do_gnt = 1'b1;
               end else begin
                  state_d = EVT_IDLE;
               end
            end
         end
         default: state_d = EVT_IDLE;
      endcase
      if (do_gnt) begin
         ptr_d = gnt_id;
         id_d  = gnt_id;
      end
   end

   // Pending/overflow update; a rise on the source being granted re-arms it
   // instead of counting as lost, and a new overflow wins over a clear.
   always_comb begin
      evt_d_d = evt_i;
      gnt_vec = do_gnt ? gnt : '0;
      ovf_set = cap & pend_q & ~gnt_vec;
      pend_d  = (pend_q & ~gnt_vec) | cap;
      ovf_d   = (ovf_q & ~ovf_clr_i) | ovf_set;
   end

   // State registers; edge detectors reset high so a level held through
   // reset release is not seen as an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EVT_IDLE;
         evt_d_q <= '1;
         pend_q  <= '0;
         ovf_q   <= '0;
         ptr_q   <= ID_W'(N_EVT - 1);
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         evt_d_q <= evt_d_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
      end
   end

   assign evt_valid_o = (state_q == EVT_PRESENT);
   assign evt_id_o    = id_q;
   assign pend_o      = pend_q;
   assign ovf_o       = ovf_q;

`ifdef UART_EVT_OVF_CNT_EN
   logic [N_EVT-1:0][CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   // Saturating lost-event counters; increment in a clear cycle leaves 1.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      for (int k = 0; k < N_EVT; k++) begin
         if (ovf_set[k]) begin
            if (ovf_clr_i[k]) begin
               ovf_cnt_d[k] = CNT_W'(1);
            end else if (!(&ovf_cnt_q[k])) begin
               ovf_cnt_d[k] = ovf_cnt_q[k] + CNT_W'(1);
            end
         end else if (ovf_clr_i[k]) begin
            ovf_cnt_d[k] = '0;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt_o = ovf_cnt_q;
`else
   assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_uart_evt_sched.sv
// Self-checking bench for uart_evt_sched (N_EVT=4, CNT_W=8).
module tb_uart_evt_sched;

   localparam int N  = 4;
   localparam int CW = 8;
`ifdef UART_EVT_OVF_CNT_EN
   localparam bit HAS_CNT = 1'b1;
`else
   localparam bit HAS_CNT = 1'b0;
`endif
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    evt_i, evt_mask_i, ovf_clr_i;
   logic          evt_ready_i;
   logic          evt_valid_o;
   logic [1:0]    evt_id_o;
   logic [3:0]    pend_o, ovf_o;
   logic [31:0]   ovf_cnt_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit         m_valid;
   int         m_id, m_ptr;
   bit [3:0]   m_pend, m_ovf, m_prev;
   int         m_cnt[4];

   uart_evt_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .evt_i       (evt_i),
      .evt_mask_i  (evt_mask_i),
      .evt_ready_i (evt_ready_i),
      .evt_valid_o (evt_valid_o),
      .evt_id_o    (evt_id_o),
      .pend_o      (pend_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i),
      .ovf_cnt_o   (ovf_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_cnt_vec();
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*CW +: CW] = m_cnt[k][CW-1:0];
      return v;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_ptr = N - 1;
      m_pend = '0; m_ovf = '0; m_prev = '1;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   // One clock of the scheduler's rules, from the event-level view.
   task automatic model_clock(input bit [3:0] e, input bit [3:0] m, input bit r, input bit [3:0] c);
      bit [3:0] rise, new_pend;
      int g;
      g = -1;
      rise = e & ~m_prev;
      if (!m_valid || r) begin
         for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (g < 0 && m_pend[k] && m[k]) g = k;
         end
         if (g >= 0) begin
            m_valid = 1; m_id = g; m_ptr = g;
         end else begin
            m_valid = 0;
         end
      end
      new_pend = m_pend;
      for (int k = 0; k < N; k++) begin
         bit lost;
         lost = rise[k] && m[k] && m_pend[k] && (k != g);
         if (rise[k] && m[k]) new_pend[k] = 1;
         else if (k == g) new_pend[k] = 0;
         if (lost) begin
            m_ovf[k] = 1;
            if (HAS_CNT) m_cnt[k] = c[k] ? 1 : ((m_cnt[k] < CNT_MAX) ? m_cnt[k] + 1 : CNT_MAX);
         end else if (c[k]) begin
            m_ovf[k] = 0;
            m_cnt[k] = 0;
         end
      end
      m_pend = new_pend;
      m_prev = e;
   endtask

   task automatic step(input bit [3:0] e, input bit [3:0] m, input bit r, input bit [3:0] c);
      evt_i = e; evt_mask_i = m; evt_ready_i = r; ovf_clr_i = c;
      @(posedge clk);
      model_clock(e, m, r, c);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      evt_i = '0; evt_mask_i = 4'hF; evt_ready_i = 1'b0; ovf_clr_i = '0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({evt_valid_o, evt_id_o, pend_o, ovf_o, ovf_cnt_o} !== '0) begin
         bad++;
         $display("FAIL reset valid=%b id=%0d pend=%b ovf=%b cnt=%h required all zero",
                  evt_valid_o, evt_id_o, pend_o, ovf_o, ovf_cnt_o);
      end
      step(4'hF, 4'hF, 1, 0);
      total++;
      if (pend_o !== 4'b0000 || evt_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_level pend=%b valid=%b required pend=0000 valid=0", pend_o, evt_valid_o);
      end
      step(0, 4'hF, 1, 0);
   endtask

   task automatic test_single();
      step(4'b0100, 4'hF, 1, 0);
      total++;
      if (pend_o !== 4'b0100 || evt_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL single_pend pend=%b valid=%b required pend=0100 valid=0", pend_o, evt_valid_o);
      end
      step(4'b0100, 4'hF, 1, 0);
      total++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd2 || pend_o !== 4'b0000) begin
         bad++;
         $display("FAIL single_grant valid=%b id=%0d pend=%b required valid=1 id=2 pend=0000",
                  evt_valid_o, evt_id_o, pend_o);
      end
      step(0, 4'hF, 1, 0);
      total++;
      if (evt_valid_o !== 1'b0 || pend_o !== 4'b0000) begin
         bad++;
         $display("FAIL single_done valid=%b pend=%b required valid=0 pend=0000", evt_valid_o, pend_o);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_pend [4];
      exp_pend[0] = 4'b1110; exp_pend[1] = 4'b1100; exp_pend[2] = 4'b1000; exp_pend[3] = 4'b0000;
      apply_reset();
      step(0, 4'hF, 1, 0);
      step(4'hF, 4'hF, 1, 0);
      total++;
      if (pend_o !== 4'hF || evt_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL fair_pend pend=%b valid=%b required pend=1111 valid=0", pend_o, evt_valid_o);
      end
      for (int i = 0; i < 4; i++) begin
         step(4'hF, 4'hF, 1, 0);
         total++;
         if (evt_valid_o !== 1'b1 || evt_id_o !== 2'(i) || pend_o !== exp_pend[i]) begin
            bad++;
            $display("FAIL fair_order beat=%0d valid=%b id=%0d pend=%b required valid=1 id=%0d pend=%b",
                     i, evt_valid_o, evt_id_o, pend_o, i, exp_pend[i]);
         end
      end
      step(4'hF, 4'hF, 1, 0);
      total++;
      if (evt_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL fair_end valid=%b required 0", evt_valid_o);
      end
      step(0, 4'hF, 1, 0);
   endtask

   task automatic test_backpressure();
      step(4'b0010, 4'hF, 0, 0);
      step(0, 4'hF, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 4'hF, 0, 0);
         total++;
         if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%b id=%0d required valid=1 id=1", i, evt_valid_o, evt_id_o);
         end
      end
      step(4'b0010, 4'hF, 0, 0);
      step(0, 4'hF, 0, 0);
      total++;
      if (pend_o !== 4'b0010 || ovf_o !== 4'b0000) begin
         bad++;
         $display("FAIL bp_repend pend=%b ovf=%b required pend=0010 ovf=0000", pend_o, ovf_o);
      end
      step(4'b0010, 4'hF, 0, 0);
      total++;
      if (ovf_o !== 4'b0010) begin
         bad++;
         $display("FAIL bp_ovf ovf=%b required 0010", ovf_o);
      end
      step(0, 4'hF, 0, 4'b0010);
      total++;
      if (ovf_o !== 4'b0000) begin
         bad++;
         $display("FAIL bp_clr ovf=%b required 0000", ovf_o);
      end
      step(0, 4'hF, 1, 0);
      total++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd1 || pend_o !== 4'b0000) begin
         bad++;
         $display("FAIL bp_regrant valid=%b id=%0d pend=%b required valid=1 id=1 pend=0000",
                  evt_valid_o, evt_id_o, pend_o);
      end
      step(0, 4'hF, 1, 0);
   endtask

   task automatic test_mask();
      step(4'b0010, 4'b1101, 1, 0);
      step(0, 4'hF, 1, 0);
      total++;
      if (pend_o !== 4'b0000 || ovf_o !== 4'b0000 || evt_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL mask_drop pend=%b ovf=%b valid=%b required pend=0000 ovf=0000 valid=0",
                  pend_o, ovf_o, evt_valid_o);
      end
      step(4'b1000, 4'hF, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 4'b0111, 1, 0);
         total++;
         if (evt_valid_o !== 1'b0 || pend_o !== 4'b1000) begin
            bad++;
            $display("FAIL mask_hold cyc=%0d valid=%b pend=%b required valid=0 pend=1000", i, evt_valid_o, pend_o);
         end
      end
      step(0, 4'hF, 1, 0);
      total++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd3 || pend_o !== 4'b0000) begin
         bad++;
         $display("FAIL mask_unmask valid=%b id=%0d pend=%b required valid=1 id=3 pend=0000",
                  evt_valid_o, evt_id_o, pend_o);
      end
      step(0, 4'hF, 1, 0);
   endtask

   task automatic test_reset_mid();
      step(4'b1011, 4'hF, 0, 0);
      step(4'b1011, 4'hF, 0, 0);
      total++;
      if (evt_valid_o !== 1'b1 || evt_id_o !== 2'd0 || pend_o !== 4'b1010) begin
         bad++;
         $display("FAIL rstmid_pre valid=%b id=%0d pend=%b required valid=1 id=0 pend=1010",
                  evt_valid_o, evt_id_o, pend_o);
      end
      evt_i = 4'hF;
      rst_n = 1'b0;
      #1;
      total++;
      if ({evt_valid_o, evt_id_o, pend_o, ovf_o, ovf_cnt_o} !== '0) begin
         bad++;
         $display("FAIL rstmid_async valid=%b id=%0d pend=%b ovf=%b cnt=%h required all zero",
                  evt_valid_o, evt_id_o, pend_o, ovf_o, ovf_cnt_o);
      end
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(4'hF, 4'hF, 1, 0);
         total++;
         if (evt_valid_o !== 1'b0 || pend_o !== 4'b0000 || ovf_o !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_level cyc=%0d valid=%b pend=%b ovf=%b required valid=0 pend=0000 ovf=0000",
                     i, evt_valid_o, pend_o, ovf_o);
         end
      end
      step(0, 4'hF, 1, 0);
   endtask

   task automatic test_random();
      bit [3:0] e, m, c;
      bit r;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         e = 4'($urandom);
         m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         r = ($urandom_range(0, 2) != 0);
         c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         step(e, m, r, c);
         total++;
         if (evt_valid_o !== m_valid || evt_id_o !== 2'(m_id) || pend_o !== m_pend ||
             ovf_o !== m_ovf || ovf_cnt_o !== m_cnt_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got v=%b id=%0d p=%b o=%b c=%h want v=%b id=%0d p=%b o=%b c=%h",
                     i, evt_valid_o, evt_id_o, pend_o, ovf_o, ovf_cnt_o,
                     m_valid, m_id, m_pend, m_ovf, m_cnt_vec());
         end
      end
   endtask

   task automatic test_ovf_cnt();
      int exp_sat;
      exp_sat = HAS_CNT ? 255 : 0;
      apply_reset();
      step(0, 4'hF, 0, 0);
      step(4'b0001, 4'hF, 0, 0);
      step(0, 4'hF, 0, 0);
      step(4'b0001, 4'hF, 0, 0);
      for (int i = 1; i <= 300; i++) begin
         step(0, 4'hF, 0, 0);
         step(4'b0001, 4'hF, 0, 0);
         if (i == 254 || i == 255 || i == 300) begin
            total++;
            if (ovf_cnt_o[7:0] !== 8'((i < exp_sat) ? i : exp_sat) || ovf_o[0] !== 1'b1) begin
               bad++;
               $display("FAIL cnt_sat n=%0d cnt=%0d ovf=%b required cnt=%0d ovf=1",
                        i, ovf_cnt_o[7:0], ovf_o[0], (i < exp_sat) ? i : exp_sat);
            end
         end
      end
      step(0, 4'hF, 0, 4'b0001);
      total++;
      if (ovf_cnt_o !== 32'h0 || ovf_o !== 4'b0000) begin
         bad++;
         $display("FAIL cnt_clr cnt=%h ovf=%b required cnt=0 ovf=0000", ovf_cnt_o, ovf_o);
      end
      step(4'b0001, 4'hF, 0, 4'b0001);
      total++;
      if (ovf_cnt_o[7:0] !== 8'(HAS_CNT ? 1 : 0) || ovf_o[0] !== 1'b1) begin
         bad++;
         $display("FAIL cnt_inc_beats_clr cnt=%0d ovf=%b required cnt=%0d ovf=1",
                  ovf_cnt_o[7:0], ovf_o[0], HAS_CNT ? 1 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_mask();
      test_reset_mid();
      test_random();
      test_ovf_cnt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
